// File: rtl/rcn2mem_slave_pkg.sv
// RCN ring word layout and slave FSM encodings.
// Shared by the ring slave and its companion master.
package rcn2mem_slave_pkg;

   localparam int RCN_W    = 69;
   localparam int RCN_DATA = 0;
   localparam int RCN_SEQ  = 32;
   localparam int RCN_ADDR = 34;
   localparam int RCN_MASK = 56;
   localparam int RCN_ID   = 60;
   localparam int RCN_WR   = 66;
   localparam int RCN_PEND = 67;
   localparam int RCN_VAL  = 68;

   typedef struct packed {
      logic        valid;
      logic        pend;
      logic        wr;
      logic [5:0]  id;
      logic [3:0]  mask;
      logic [21:0] addr;
      logic [1:0]  seq;
      logic [31:0] data;
   } rcn_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Turn a request word into its response header.
   function automatic rcn_t rcn_resp(input rcn_t r);
      rcn_t o;
      o       = r;
      o.valid = 1'b1;
      o.pend  = 1'b0;
      return o;
   endfunction

endpackage

// File: rtl/rcn2mem_slave.sv
// RCN ring slave: claims requests in its window, runs them on
// a req/ack memory port and re-inserts the response into the ring.
module rcn2mem_slave
   import rcn2mem_slave_pkg::*;
#(
   parameter logic [21:0] ADDR_MASK = 22'h3F0000,
   parameter logic [21:0] ADDR_BASE = 22'h000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [68:0] rcn_in,
   output logic [68:0] rcn_out,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [21:0] mem_addr,
   output logic [3:0]  mem_mask,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   rcn_t   r_rin;
   rcn_t   r_rout;
   rcn_t   r_buf;
   state_t r_state;
   logic   r_mem_req;

   rcn_t   w_rout_nxt;
   rcn_t   w_buf_nxt;
   state_t w_state_nxt;
   logic   w_req_nxt;
   logic   w_my_req;

   assign w_my_req = r_rin.valid & r_rin.pend &
                     ((r_rin.addr & ADDR_MASK) == ADDR_BASE);

   always_comb begin
      w_state_nxt = r_state;
      w_rout_nxt  = r_rin;
      w_buf_nxt   = r_buf;
      w_req_nxt   = r_mem_req;
      unique case (r_state)
         ST_IDLE: begin
            if (w_my_req) begin
               // Buffer already holds the response header.
               w_buf_nxt   = rcn_resp(r_rin);
               w_rout_nxt  = '0;
               w_req_nxt   = 1'b1;
               w_state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (r_mem_req && mem_ack) begin
               w_req_nxt = 1'b0;
               if (!r_buf.wr)
                  w_buf_nxt.data = mem_rdata;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (!r_rin.valid) begin
               w_rout_nxt  = r_buf;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_rin     <= '0;
         r_rout    <= '0;
         r_buf     <= '0;
         r_mem_req <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rin     <= rcn_t'(rcn_in);
         r_rout    <= w_rout_nxt;
         r_buf     <= w_buf_nxt;
         r_mem_req <= w_req_nxt;
      end
   end

   assign rcn_out   = r_rout;
   assign mem_req   = r_mem_req;
   assign mem_wr    = r_buf.wr;
   assign mem_addr  = r_buf.addr;
   assign mem_mask  = r_buf.mask;
   assign mem_wdata = r_buf.data;

endmodule

// File: tb/tb_rcn2mem_slave.sv
// Directed bench for rcn2mem_slave with a transaction-level
// ring model checked every cycle plus literal spot checks.
module tb_rcn2mem_slave;

   localparam logic [21:0] MSK  = 22'h3F0000;
   localparam logic [21:0] BASE = 22'h000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [68:0] rcn_in = '0;
   logic [68:0] rcn_out;
   logic        mem_req;
   logic        mem_wr;
   logic [21:0] mem_addr;
   logic [3:0]  mem_mask;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int nvec = 0;
   int nerr = 0;

   rcn2mem_slave #(.ADDR_MASK(MSK), .ADDR_BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n),
      .rcn_in(rcn_in), .rcn_out(rcn_out),
      .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_mask(mem_mask),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [68:0] mk(
      input logic v, input logic p, input logic w,
      input logic [5:0] id, input logic [3:0] m,
      input logic [21:0] a, input logic [1:0] s,
      input logic [31:0] d);
      return {v, p, w, id, m, a, s, d};
   endfunction

   function automatic logic hit(input logic [68:0] w);
      logic [21:0] a;
      a = w[55:34];
      return w[68] & w[67] & ((a & MSK) == BASE);
   endfunction

   task automatic chk(input string nm,
                      input logic [68:0] act,
                      input logic [68:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   // Model: a ring slot stream plus one owned transaction.
   logic [68:0] m_rin = '0;
   logic [68:0] m_txn = '0;
   logic [68:0] e_rout = '0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_req = 1'b0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_rin = '0; m_txn = '0; e_rout = '0;
         m_busy = 0; m_done = 0; m_req = 0;
      end else begin
         logic pre_req;
         pre_req = m_req;
         if (!m_busy && hit(m_rin)) begin
            e_rout = '0;
            m_txn  = m_rin;
            m_busy = 1; m_done = 0; m_req = 1;
         end else if (m_busy && m_done && !m_rin[68]) begin
            e_rout = m_txn;
            e_rout[68] = 1'b1;
            e_rout[67] = 1'b0;
            m_busy = 0; m_done = 0;
         end else begin
            e_rout = m_rin;
         end
         if (pre_req && mem_ack) begin
            m_req  = 0;
            m_done = 1;
            if (!m_txn[66]) m_txn[31:0] = mem_rdata;
         end
         m_rin = rcn_in;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("ring_out", rcn_out, e_rout);
      chk("mem_req", {68'd0, mem_req}, {68'd0, m_req});
      if (m_req) begin
         chk("mem_addr", {47'd0, mem_addr}, {47'd0, m_txn[55:34]});
         chk("mem_wr", {68'd0, mem_wr}, {68'd0, m_txn[66]});
         chk("mem_mask", {65'd0, mem_mask}, {65'd0, m_txn[59:56]});
         chk("mem_wdata", {37'd0, mem_wdata}, {37'd0, m_txn[31:0]});
      end
   end

   task automatic send(input logic [68:0] w);
      @(negedge clk); rcn_in = w;
      @(negedge clk); rcn_in = '0;
   endtask

   task automatic wait_req(input string nm);
      int k;
      k = 0;
      while (!mem_req && k < 10) begin
         @(negedge clk); k++;
      end
      chk(nm, {68'd0, mem_req}, 69'd1);
   endtask

   task automatic ack(input int dly, input logic [31:0] d);
      repeat (dly) @(negedge clk);
      mem_ack = 1'b1; mem_rdata = d;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic wait_word(input string nm, input logic [68:0] exp,
                            input int maxc);
      int k;
      logic seen;
      seen = 0;
      for (k = 0; k < maxc && !seen; k++) begin
         @(negedge clk);
         if (rcn_out === exp) seen = 1;
      end
      chk(nm, seen ? exp : rcn_out, exp);
   endtask

   logic [68:0] w;
   logic [68:0] b;
   int vcnt;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_out", rcn_out, 69'd0);
      chk("reset_req", {68'd0, mem_req}, 69'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Read hit.
      w = mk(1, 1, 0, 6'h3F, 4'hF, 22'h000010, 2'd1, 32'h0);
      send(w);
      wait_req("rd_req");
      chk("rd_addr", {47'd0, mem_addr}, 69'h10);
      chk("rd_wr", {68'd0, mem_wr}, 69'd0);
      ack(2, 32'hDEADBEEF);
      wait_word("rd_resp",
         mk(1, 0, 0, 6'h3F, 4'hF, 22'h000010, 2'd1, 32'hDEADBEEF), 10);

      // Write hit.
      w = mk(1, 1, 1, 6'h05, 4'h3, 22'h000020, 2'd2, 32'h12345678);
      send(w);
      wait_req("wr_req");
      chk("wr_wr", {68'd0, mem_wr}, 69'd1);
      chk("wr_mask", {65'd0, mem_mask}, 69'h3);
      chk("wr_wdata", {37'd0, mem_wdata}, 69'h12345678);
      ack(1, 32'hFFFF0000);
      wait_word("wr_resp",
         mk(1, 0, 1, 6'h05, 4'h3, 22'h000020, 2'd2, 32'h12345678), 10);

      // Miss passes through two cycles later.
      w = mk(1, 1, 0, 6'h11, 4'hF, 22'h010000, 2'd0, 32'hCAFE0001);
      @(negedge clk); rcn_in = w;
      @(negedge clk); rcn_in = '0;
      @(negedge clk);
      chk("miss_pass", rcn_out, w);
      chk("miss_noreq", {68'd0, mem_req}, 69'd0);

      // Stray ack while idle is ignored.
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h55;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      chk("stray_ack", {68'd0, mem_req}, 69'd0);

      // Second hit while busy continues round the ring.
      w = mk(1, 1, 0, 6'h01, 4'hF, 22'h000100, 2'd3, 32'h0);
      b = mk(1, 1, 1, 6'h02, 4'hC, 22'h000200, 2'd0, 32'hA5A5A5A5);
      send(w);
      wait_req("busy_req");
      send(b);
      @(negedge clk);
      chk("busy_pass", rcn_out, b);
      ack(1, 32'h0BADF00D);
      wait_word("busy_resp",
         mk(1, 0, 0, 6'h01, 4'hF, 22'h000100, 2'd3, 32'h0BADF00D), 10);

      // Full ring: response waits for the first empty slot.
      w = mk(1, 1, 0, 6'h07, 4'hF, 22'h000300, 2'd1, 32'h0);
      send(w);
      wait_req("full_req");
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rcn_out[68]) vcnt++;
         rcn_in = (i < 7) ?
            mk(1, 0, 0, 6'(i + 8), 4'hF, 22'(i), 2'd0, 32'(i)) : '0;
         if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h77; end
         if (i == 3) begin mem_ack = 1'b0; mem_rdata = '0; end
      end
      chk("full_count", 69'(vcnt), 69'd8);

      // Reset in the middle of an access.
      w = mk(1, 1, 0, 6'h09, 4'hF, 22'h000040, 2'd2, 32'h0);
      send(w);
      wait_req("rst_req");
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_low", {68'd0, mem_req}, 69'd0);
      chk("rst_out_zero", rcn_out, 69'd0);
      @(negedge clk);
      rst_n = 1'b1;
      w = mk(1, 1, 1, 6'h0A, 4'h1, 22'h000050, 2'd3, 32'h00C0FFEE);
      send(w);
      wait_req("post_rst_req");
      ack(0, 32'h0);
      wait_word("post_rst_resp",
         mk(1, 0, 1, 6'h0A, 4'h1, 22'h000050, 2'd3, 32'h00C0FFEE), 10);
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
